// File: rtl/vga_timing.sv
// Raster timing generator for 640x480@60Hz VGA (800x525 total at a 25 MHz pixel clock).
// Free-running pixel/line counters with zero-latency decoded sync, display-enable and frame pulse.
module vga_timing #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_frame,
  output logic [11:0] o_h,
  output logic [11:0] o_v,
  output logic        o_de
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS_END    = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS_END    = 12'(V_VISIBLE);
  localparam logic [11:0] H_SYNC_START = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_START = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] V_SYNC_END   = 12'(V_VISIBLE + V_FP + V_SYNC);

  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;

  // The line counter only advances when the pixel counter wraps, so both wrap together at frame end.
  always_comb begin
    h_d = h_q + 12'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = 12'd0;
      if (v_q == V_LAST) begin
        v_d = 12'd0;
      end else begin
        v_d = v_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= 12'd0;
      v_q <= 12'd0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign o_h     = h_q;
  assign o_v     = v_q;
  assign o_de    = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign o_hs    = ((h_q >= H_SYNC_START) && (h_q < H_SYNC_END)) ? HS_POL : ~HS_POL;
  assign o_vs    = ((v_q >= V_SYNC_START) && (v_q < V_SYNC_END)) ? VS_POL : ~VS_POL;
  assign o_frame = (h_q == 12'd0) && (v_q == 12'd0);

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: a full-size 640x480 instance for reset, line and hsync behaviour, and a
// shrunken active-high-sync instance for frame wrap, vsync, frame period and mid-frame reset.
module tb_vga_timing;

  logic        clk;
  logic        fReset, sReset;
  logic        fHs, fVs, fFrame, fDe;
  logic [11:0] fH, fV;
  logic        sHs, sVs, sFrame, sDe;
  logic [11:0] sH, sV;
  int          testsRun;
  int          testsFailed;

  vga_timing uFull (
    .clk(clk), .reset(fReset), .o_hs(fHs), .o_vs(fVs), .o_frame(fFrame),
    .o_h(fH), .o_v(fV), .o_de(fDe)
  );

  // 15 pixels x 11 lines = 165 clocks per frame; 8x6 visible = 48 enabled clocks.
  vga_timing #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) uSmall (
    .clk(clk), .reset(sReset), .o_hs(sHs), .o_vs(sVs), .o_frame(sFrame),
    .o_h(sH), .o_v(sV), .o_de(sDe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int nCycles);
    for (int i = 0; i < nCycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Walks the small instance from a frame pulse to the next one, gathering per-frame statistics.
  task automatic measureSmallFrame(input string tag);
    int   period = 0, deCnt = 0, hsCnt = 0, vsCnt = 0;
    int   vsFirst = -1, vsLast = -1, badVsEdge = 0, maxH = 0, maxV = 0;
    int   lastH = 0, lastV = 0;
    bit   seen = 1'b0;
    logic prevVs;
    prevVs = sVs;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (sDe === 1'b1) deCnt++;
      if (sHs === 1'b1) hsCnt++;
      if (sVs === 1'b1) begin
        vsCnt++;
        if (vsFirst < 0) vsFirst = int'(sV);
        vsLast = int'(sV);
      end
      if ((sVs !== prevVs) && (sH != 12'd0)) badVsEdge++;
      prevVs = sVs;
      if (int'(sH) > maxH) maxH = int'(sH);
      if (int'(sV) > maxV) maxV = int'(sV);
      lastH = int'(sH);
      lastV = int'(sV);
      applyStimulus(1);
      period++;
      if (sFrame === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, " frame pulse seen"}, 32'(seen), 32'd1);
    checkOutput({tag, " frame period"}, period, 165);
    checkOutput({tag, " de clocks"}, deCnt, 48);
    checkOutput({tag, " hs active clocks"}, hsCnt, 33);
    checkOutput({tag, " vs active clocks"}, vsCnt, 30);
    checkOutput({tag, " vs first line"}, vsFirst, 8);
    checkOutput({tag, " vs last line"}, vsLast, 9);
    checkOutput({tag, " vs edge off h0"}, badVsEdge, 0);
    checkOutput({tag, " max h"}, maxH, 14);
    checkOutput({tag, " max v"}, maxV, 10);
    checkOutput({tag, " h before wrap"}, lastH, 14);
    checkOutput({tag, " v before wrap"}, lastV, 10);
    checkOutput({tag, " h after wrap"}, sH, 0);
    checkOutput({tag, " v after wrap"}, sV, 0);
  endtask

  initial begin
    int hsLow, deInSync, deLine, firstLow, lastLow;
    testsRun    = 0;
    testsFailed = 0;
    fReset      = 1'b1;
    sReset      = 1'b1;

    applyStimulus(2);
    fReset = 1'b0;
    sReset = 1'b0;
    checkOutput("reset h", fH, 0);
    checkOutput("reset v", fV, 0);
    checkOutput("reset frame", fFrame, 1);
    checkOutput("reset de", fDe, 1);
    checkOutput("reset hs", fHs, 1);
    checkOutput("reset vs", fVs, 1);
    applyStimulus(1);
    checkOutput("post-reset h", fH, 1);
    checkOutput("post-reset frame", fFrame, 0);

    applyStimulus(638);
    checkOutput("h639 h", fH, 639);
    checkOutput("h639 de", fDe, 1);
    applyStimulus(1);
    checkOutput("h640 de", fDe, 0);
    applyStimulus(160);
    checkOutput("line1 start h", fH, 0);
    checkOutput("line1 start v", fV, 1);

    hsLow = 0; deInSync = 0; deLine = 0; firstLow = -1; lastLow = -1;
    for (int i = 0; i < 800; i++) begin
      if (fDe === 1'b1) deLine++;
      if (fHs === 1'b0) begin
        hsLow++;
        if (fDe !== 1'b0) deInSync++;
        if (firstLow < 0) firstLow = int'(fH);
        lastLow = int'(fH);
      end
      applyStimulus(1);
    end
    checkOutput("hs low clocks", hsLow, 96);
    checkOutput("hs first low h", firstLow, 656);
    checkOutput("hs last low h", lastLow, 751);
    checkOutput("de during hsync", deInSync, 0);
    checkOutput("de clocks line1", deLine, 640);

    applyStimulus(3199);
    checkOutput("wrap pre h", fH, 799);
    checkOutput("wrap pre v", fV, 5);
    applyStimulus(1);
    checkOutput("wrap post h", fH, 0);
    checkOutput("wrap post v", fV, 6);
    checkOutput("wrap post frame", fFrame, 0);
    checkOutput("wrap post vs", fVs, 1);

    applyStimulus(300);
    checkOutput("midline h", fH, 300);
    fReset = 1'b1;
    applyStimulus(1);
    fReset = 1'b0;
    checkOutput("midline reset h", fH, 0);
    checkOutput("midline reset v", fV, 0);
    checkOutput("midline reset frame", fFrame, 1);
    applyStimulus(1);
    checkOutput("midline resume h", fH, 1);

    sReset = 1'b1;
    applyStimulus(1);
    sReset = 1'b0;
    checkOutput("small reset h", sH, 0);
    checkOutput("small reset frame", sFrame, 1);
    checkOutput("small reset hs", sHs, 0);
    checkOutput("small reset vs", sVs, 0);
    measureSmallFrame("frame1");
    measureSmallFrame("frame2");

    applyStimulus(65);
    checkOutput("midframe h", sH, 5);
    checkOutput("midframe v", sV, 4);
    sReset = 1'b1;
    applyStimulus(1);
    sReset = 1'b0;
    checkOutput("midframe reset h", sH, 0);
    checkOutput("midframe reset v", sV, 0);
    checkOutput("midframe reset frame", sFrame, 1);
    measureSmallFrame("resumed");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
